token_inject_bridge: RTL and testbench

- Synchronous-to-self-timed injector that sits directly upstream of a CELEMENT memory stage.
- Accepts tokens, each carrying one exit bit, from clocked logic through a valid/ready port and buffers them in a small FIFO.
- Drives each token into the stage's SENDIN/EXBIN pair using a 4-phase return-to-zero handshake.
- Synchronises the stage's asynchronous ACKOUT back into the clock domain.

---
 rtl/token_inject_bridge.sv | 158 +++++++++++++++
 tb/tb_token_inject_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_inject_bridge.sv
// Clocked-to-self-timed token injector: a small FIFO feeds a 4-phase RZ
// handshake (SENDOUT/EXBOUT vs. ACKIN) into a CELEMENT memory stage.
module token_inject_bridge #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   IN_VALID,
  input  logic                   IN_EXB,
  output logic                   IN_READY,
  output logic                   SENDOUT,
  output logic                   EXBOUT,
  input  logic                   ACKIN,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic [CNT_W-1:0]       TOKEN_CNT,
  output logic                   ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_REL, S_ERR} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH-1:0]       mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sendout_q, sendout_d;
  logic                   exbout_q, exbout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [TW-1:0]          timer_q, timer_d;

  logic push, pop, not_empty, ack_s, timed_out, in_ready;

  assign in_ready  = (level_q < LW'(DEPTH));
  assign not_empty = (level_q != '0);
  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign push      = IN_VALID && in_ready;

  always_comb begin
    state_d   = state_q;
    sendout_d = sendout_q;
    exbout_d  = exbout_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    timer_d   = timer_q + 1'b1;
    pop       = 1'b0;
    timed_out = (TIMEOUT_CYC != 0) && (timer_d == TW'(TIMEOUT_CYC));
    sync_d    = {sync_q[SYNC_STAGES-2:0], ACKIN};

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (not_empty) begin
          pop      = 1'b1;
          exbout_d = mem_q[rd_ptr_q];
          state_d  = S_SETUP;
        end
      end
      // EXBOUT was loaded on entry, so it has had a full cycle to settle here.
      S_SETUP: begin
        if (!ack_s) begin
          sendout_d = 1'b1;
          timer_d   = '0;
          state_d   = S_REQ;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          sendout_d = 1'b0;
          cnt_d     = cnt_q + 1'b1;
          timer_d   = '0;
          state_d   = S_REL;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_REL: begin
        if (!ack_s) begin
          timer_d = '0;
          if (not_empty) begin
            pop      = 1'b1;
            exbout_d = mem_q[rd_ptr_q];
            state_d  = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_ERR:   timer_d = timer_q;
      default: state_d = S_IDLE;
    endcase

    // ERR is flagged on the same edge that drops the request.
    if (state_d == S_ERR) begin
      sendout_d = 1'b0;
      err_d     = 1'b1;
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = IN_EXB;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    busy_d   = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sync_q    <= '0;
      sendout_q <= 1'b0;
      exbout_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sync_q    <= sync_d;
      sendout_q <= sendout_d;
      exbout_q  <= exbout_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      timer_q   <= timer_d;
    end
  end

  assign IN_READY  = in_ready;
  assign SENDOUT   = sendout_q;
  assign EXBOUT    = exbout_q;
  assign BUSY      = busy_q;
  assign LEVEL     = level_q;
  assign TOKEN_CNT = cnt_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_token_inject_bridge.sv
// Directed bench for token_inject_bridge: vector table for FIFO fill plus
// hand sequences for handshake, timeout, mid-handshake reset and count wrap.
module tb_token_inject_bridge;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 4;
  localparam int TMO   = 16;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             IN_VALID = 1'b0;
  logic             IN_EXB = 1'b0;
  logic             IN_READY, SENDOUT, EXBOUT, BUSY, ERR;
  logic             ACKIN = 1'b0;
  logic [2:0]       LEVEL;
  logic [CNT_W-1:0] TOKEN_CNT;

  token_inject_bridge #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_EXB(IN_EXB), .IN_READY(IN_READY),
    .SENDOUT(SENDOUT), .EXBOUT(EXBOUT), .ACKIN(ACKIN), .BUSY(BUSY), .LEVEL(LEVEL),
    .TOKEN_CNT(TOKEN_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Stage model: ACKIN follows SENDOUT about three cycles later, or is forced.
  logic       ack_mode = 1'b0;
  logic       ack_force = 1'b0;
  logic [2:0] hist = '0;
  always @(negedge CLK) begin
    hist  = {hist[1:0], SENDOUT};
    ACKIN = ack_mode ? hist[2] : ack_force;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // EXBOUT must hold across any cycle with SENDOUT or ACKIN high, which also
  // forces it to be settled a cycle before SENDOUT rises.
  logic mon_en = 1'b0;
  logic prev_exb = 1'b0, prev_send = 1'b0, prev_ack = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (mon_en && (prev_send || SENDOUT || prev_ack))
      check("exb_stable", EXBOUT, prev_exb);
    prev_exb  = EXBOUT;
    prev_send = SENDOUT;
    prev_ack  = ACKIN;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    IN_VALID = 1'b0;
    IN_EXB   = 1'b0;
    RESET    = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic push(input logic b);
    int k = 0;
    while (!IN_READY && k < 200) begin
      tick();
      k++;
    end
    check("push_ready", IN_READY, 1'b1);
    IN_VALID = 1'b1;
    IN_EXB   = b;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (BUSY && k < budget) begin
      tick();
      k++;
    end
    check(name, BUSY, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic       b;
    logic       rdy;
    logic [2:0] lvl;
    logic       exb;
    logic       snd;
  } vec_t;

  vec_t       tbl[7];
  logic [4:0] got;
  logic [4:0] exp_seq;
  int         ng;
  logic       ps;

  initial begin
    // Fill with ACKIN held low: the first token is popped into the handshake,
    // so five are accepted before IN_READY drops; the sixth is refused.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    exp_seq = 5'b01101; // delivery order 1,0,1,1,0 from bit 0 upward

    // Reset state and single-token latency.
    do_reset();
    check("rst_sendout", SENDOUT, 1'b0);
    check("rst_exbout", EXBOUT, 1'b0);
    check("rst_level", LEVEL, 3'd0);
    check("rst_ready", IN_READY, 1'b1);
    check("rst_cnt", TOKEN_CNT, 4'd0);
    check("rst_err", ERR, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    ack_mode = 1'b1;
    mon_en   = 1'b1;
    IN_VALID = 1'b1;
    IN_EXB   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check("t0_level", LEVEL, 3'd1);
    check("t0_sendout", SENDOUT, 1'b0);
    tick();
    check("t1_exbout", EXBOUT, 1'b1);
    check("t1_sendout", SENDOUT, 1'b0);
    tick();
    check("t2_sendout", SENDOUT, 1'b1);
    wait_idle(60, "single_idle");
    check("single_cnt", TOKEN_CNT, 4'd1);
    check("single_sendout", SENDOUT, 1'b0);

    // Fill and drain.
    do_reset();
    ack_mode  = 1'b0;
    ack_force = 1'b0;
    mon_en    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      IN_VALID = tbl[i].v;
      IN_EXB   = tbl[i].b;
      tick();
      check($sformatf("fill%0d_ready", i), IN_READY, tbl[i].rdy);
      check($sformatf("fill%0d_level", i), LEVEL, tbl[i].lvl);
      check($sformatf("fill%0d_exbout", i), EXBOUT, tbl[i].exb);
      check($sformatf("fill%0d_sendout", i), SENDOUT, tbl[i].snd);
    end
    IN_VALID = 1'b0;
    ack_mode = 1'b1;
    got = '0;
    ng  = 0;
    ps  = SENDOUT;
    for (int k = 0; k < 300 && BUSY; k++) begin
      tick();
      if (ps && !SENDOUT && ng < 5) begin
        got[ng] = EXBOUT;
        ng++;
      end
      ps = SENDOUT;
    end
    check("drain_tokens", 16'(ng), 16'd5);
    check("drain_order", got, exp_seq);
    check("drain_cnt", TOKEN_CNT, 4'd5);
    check("drain_level", LEVEL, 3'd0);
    check("drain_busy", BUSY, 1'b0);

    // Timeout in REQ with ACKIN stuck low.
    do_reset();
    ack_mode  = 1'b0;
    ack_force = 1'b0;
    IN_VALID  = 1'b1;
    IN_EXB    = 1'b0;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    check("tmo_sendout_up", SENDOUT, 1'b1);
    repeat (15) tick();
    check("tmo_err_early", ERR, 1'b0);
    check("tmo_sendout_held", SENDOUT, 1'b1);
    tick();
    check("tmo_err_set", ERR, 1'b1);
    check("tmo_sendout_drop", SENDOUT, 1'b0);
    IN_VALID = 1'b1;
    IN_EXB   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (5) tick();
    check("tmo_err_sticky", ERR, 1'b1);
    check("tmo_no_pop", LEVEL, 3'd1);
    check("tmo_ready", IN_READY, 1'b1);
    check("tmo_sendout_low", SENDOUT, 1'b0);
    RESET = 1'b1;
    #1;
    check("tmo_reset_clears", ERR, 1'b0);
    tick();
    RESET = 1'b0;

    // Reset mid-handshake while the stage is still acknowledging.
    do_reset();
    ack_mode = 1'b1;
    IN_VALID = 1'b1;
    IN_EXB   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int k = 0; k < 20 && !ACKIN; k++) tick();
    check("mid_ack_seen", ACKIN, 1'b1);
    ack_force = 1'b1;
    ack_mode  = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check("mid_async_sendout", SENDOUT, 1'b0);
    tick();
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    IN_VALID = 1'b1;
    IN_EXB   = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (6) tick();
    check("mid_hold_sendout", SENDOUT, 1'b0);
    check("mid_hold_exbout", EXBOUT, 1'b1);
    check("mid_hold_busy", BUSY, 1'b1);
    ack_force = 1'b0;
    tick();
    tick();
    check("mid_sync_lag", SENDOUT, 1'b0);
    tick();
    check("mid_sendout_rise", SENDOUT, 1'b1);
    ack_mode = 1'b1;
    wait_idle(60, "mid_idle");
    check("mid_cnt", TOKEN_CNT, 4'd1);

    // 17 tokens through a 4-bit counter.
    do_reset();
    ack_mode = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 17; i++) push(1'(i));
    wait_idle(400, "wrap_idle");
    check("wrap_cnt", TOKEN_CNT, 4'd1);
    check("wrap_err", ERR, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
